// File: rtl/trace_pixel_scheduler.sv
// trace_pixel_scheduler: walks a frame in raster order, issuing one ray request
// per pixel, writing each returned colour to the frame buffer and accumulating
// per-frame collision flags.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   frame_start_i             one-cycle frame request, honoured only when idle
//   trace_req_valid_o/ready_i ray request handshake
//   trace_col_o/trace_row_o   pixel being requested
//   trace_rsp_valid_i         single-cycle tracer result strobe
//   trace_rsp_color_i/hit_i   shaded colour and collision indication
//   fb_we_o/col_o/row_o/data_o  frame buffer write port
//   frame_busy_o              frame in progress (low again during frame_done_o)
//   frame_done_o              one-cycle end-of-frame pulse
//   collision_flags_o         {left, right, any, bottom}, latched at frame end
//   timeout_err_o             sticky; some pixel never got a response
module trace_pixel_scheduler #(
    parameter int COLS    = 128,
    parameter int ROWS    = 64,
    parameter int COL_W   = 7,
    parameter int ROW_W   = 6,
    parameter int COLOR_W = 12,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start_i,
    output logic               trace_req_valid_o,
    input  logic               trace_req_ready_i,
    output logic [COL_W-1:0]   trace_col_o,
    output logic [ROW_W-1:0]   trace_row_o,
    input  logic               trace_rsp_valid_i,
    input  logic [COLOR_W-1:0] trace_rsp_color_i,
    input  logic               trace_rsp_hit_i,
    output logic               fb_we_o,
    output logic [COL_W-1:0]   fb_col_o,
    output logic [ROW_W-1:0]   fb_row_o,
    output logic [COLOR_W-1:0] fb_data_o,
    output logic               frame_busy_o,
    output logic               frame_done_o,
    output logic [3:0]         collision_flags_o,
    output logic               timeout_err_o
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               hit_q, hit_d;
    logic [3:0]         acc_q, acc_d;
    logic [3:0]         flags_q, flags_d;
    logic               terr_q, terr_d;
    logic               last_col, last_row;

    assign last_col = col_q == COL_W'(COLS - 1);
    assign last_row = row_q == ROW_W'(ROWS - 1);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        tmo_d   = tmo_q;
        color_d = color_q;
        hit_d   = hit_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: if (frame_start_i) begin
                col_d   = '0;
                row_d   = '0;
                acc_d   = '0;
                state_d = ISSUE;
            end
            ISSUE: if (trace_req_ready_i) begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (trace_rsp_valid_i) begin
                color_d = trace_rsp_color_i;
                hit_d   = trace_rsp_hit_i;
                state_d = WRITE;
            end else if (tmo_q == TMO_LAST) begin
                // Give up on this pixel: write black, count no collision.
                color_d = '0;
                hit_d   = 1'b0;
                terr_d  = 1'b1;
                state_d = WRITE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
            WRITE: begin
                if (hit_q)
                    acc_d = acc_q | {col_q == '0, last_col, 1'b1, last_row};
                // Both counters wrap on the last pixel so no out-of-range address survives.
                col_d   = last_col ? '0 : col_q + 1'b1;
                row_d   = !last_col ? row_q : last_row ? '0 : row_q + 1'b1;
                state_d = (last_col && last_row) ? DONE : ISSUE;
            end
            DONE: begin
                flags_d = acc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            tmo_q   <= '0;
            color_q <= '0;
            hit_q   <= 1'b0;
            acc_q   <= '0;
            flags_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            tmo_q   <= tmo_d;
            color_q <= color_d;
            hit_q   <= hit_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            terr_q  <= terr_d;
        end
    end

    assign trace_req_valid_o = state_q == ISSUE;
    assign trace_col_o       = col_q;
    assign trace_row_o       = row_q;
    assign fb_we_o           = state_q == WRITE;
    assign fb_col_o          = col_q;
    assign fb_row_o          = row_q;
    assign fb_data_o         = color_q;
    assign frame_busy_o      = state_q == ISSUE || state_q == WAIT || state_q == WRITE;
    assign frame_done_o      = state_q == DONE;
    assign collision_flags_o = flags_q;
    assign timeout_err_o     = terr_q;
endmodule
